// File: rtl/fnd_scan_sched.sv
// fnd_scan_sched
//   Time-multiplexed scan controller and display arbiter for a 4-digit
//   common-anode FND. A prescaler steps through the digits. The shown 16-bit
//   value is either the free-running background value or an overlay value.
//   An overlay request shows its value for HOLD_FRAMES full frames, then the
//   display goes back to the background value.
//
//   Optional feature: define FND_BLANK_LZ_EN to blank leading zeros on
//   digits 1..3. When it is undefined, every digit shows its decoded nibble.
//
// Parameters
//   DIV          clocks per digit scan tick (>= 2)
//   HOLD_FRAMES  full frames an accepted overlay is displayed (>= 1)
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_val        background value; nibble 0 drives digit 0
//   i_irq_req    overlay request (level)
//   i_irq_val    overlay value, captured on acceptance
//   o_irq_ack    one-cycle acceptance pulse
//   o_busy       high while the overlay state is active (FSM state view)
//   o_digit_sel  active-low digit enables, one-hot-zero
//   o_seg        active-low segments {dp,g,f,e,d,c,b,a}; dp is always off
//
// Handshake: a request is accepted on any edge where i_irq_req is high and
//   o_irq_ack is low. o_irq_ack is high for exactly the next cycle. A request
//   that is still high while ack is high is ignored. The requester drops the
//   request in the cycle after ack. If the request is still high one cycle
//   later, it counts as a new request.
module fnd_scan_sched #(
    parameter int DIV         = 10_000,
    parameter int HOLD_FRAMES = 500
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_val,
    input  logic        i_irq_req,
    input  logic [15:0] i_irq_val,
    output logic        o_irq_ack,
    output logic        o_busy,
    output logic [3:0]  o_digit_sel,
    output logic [7:0]  o_seg
);

    localparam int CNT_W  = $clog2(DIV);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_FULL  = HOLD_W'(HOLD_FRAMES);
    // When acceptance lands on a boundary, that frame is overlay frame 1.
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(HOLD_FRAMES - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_OVERLAY = 1'b1;

    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_idx;
    logic [15:0]       r_disp;
    logic [15:0]       r_irq_val;
    logic [HOLD_W-1:0] r_hold;
    logic [0:0]        r_state;

    logic [CNT_W-1:0]  nxt_cnt;
    logic [1:0]        nxt_idx;
    logic [15:0]       nxt_disp;
    logic [15:0]       nxt_irq_val;
    logic [HOLD_W-1:0] nxt_hold;
    logic [0:0]        nxt_state;
    logic              nxt_ack;
    logic [3:0]        nxt_nib;
    logic [7:0]        nxt_seg;

    logic tick;
    logic boundary;
    logic accept;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick     = (r_cnt == CNT_LAST);
    assign boundary = tick && (r_idx == 2'd3);
    assign accept   = i_irq_req && !o_irq_ack;

    assign nxt_cnt = tick ? '0 : r_cnt + 1'b1;
    assign nxt_idx = tick ? r_idx + 2'd1 : r_idx;

    always_comb begin
        nxt_state   = r_state;
        nxt_disp    = r_disp;
        nxt_hold    = r_hold;
        nxt_irq_val = r_irq_val;
        nxt_ack     = 1'b0;
        if (accept) begin
            nxt_irq_val = i_irq_val;
            nxt_state   = ST_OVERLAY;
            nxt_ack     = 1'b1;
            if (boundary) begin
                // Bypass so the new value appears on this very edge.
                nxt_disp = i_irq_val;
                nxt_hold = HOLD_FIRST;
            end else begin
                nxt_hold = HOLD_FULL;
            end
        end else if (boundary) begin
            if (r_state == ST_OVERLAY && r_hold != '0) begin
                nxt_hold = r_hold - 1'b1;
                nxt_disp = r_irq_val;
            end else begin
                nxt_state = ST_IDLE;
                nxt_disp  = i_val;
            end
        end
    end

    // Segments are decoded from the next index and next display value so
    // that o_seg and o_digit_sel update on the same edge.
    always_comb begin
        case (nxt_idx)
            2'd0:    nxt_nib = nxt_disp[3:0];
            2'd1:    nxt_nib = nxt_disp[7:4];
            2'd2:    nxt_nib = nxt_disp[11:8];
            default: nxt_nib = nxt_disp[15:12];
        endcase
    end

`ifdef FND_BLANK_LZ_EN
    logic blank;

    always_comb begin
        case (nxt_idx)
            2'd1:    blank = (nxt_disp[15:4]  == 12'h000);
            2'd2:    blank = (nxt_disp[15:8]  == 8'h00);
            2'd3:    blank = (nxt_disp[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end

    assign nxt_seg = blank ? 8'hFF : hex_to_seg(nxt_nib);
`else
    assign nxt_seg = hex_to_seg(nxt_nib);
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_disp      <= 16'h0000;
            r_irq_val   <= 16'h0000;
            r_hold      <= '0;
            r_state     <= ST_IDLE;
            o_irq_ack   <= 1'b0;
            o_digit_sel <= 4'b1110;
            o_seg       <= 8'hC0;
        end else begin
            r_cnt       <= nxt_cnt;
            r_idx       <= nxt_idx;
            r_disp      <= nxt_disp;
            r_irq_val   <= nxt_irq_val;
            r_hold      <= nxt_hold;
            r_state     <= nxt_state;
            o_irq_ack   <= nxt_ack;
            o_digit_sel <= ~(4'b0001 << nxt_idx);
            o_seg       <= nxt_seg;
        end
    end

    assign o_busy = (r_state == ST_OVERLAY);

endmodule

// File: tb/tb_fnd_scan_sched.sv
// Directed bench for fnd_scan_sched with DIV=4 and HOLD_FRAMES=2.
// Edge numbers in the comments count rising edges after the reset release.
// Inputs change 1 ns after a rising edge. Outputs are checked at that same
// point.
module tb_fnd_scan_sched;

    logic        clk;
    logic        rst_n;
    logic [15:0] val;
    logic        irq_req;
    logic [15:0] irq_val;
    logic        irq_ack;
    logic        busy;
    logic [3:0]  digit_sel;
    logic [7:0]  seg;

    int n_checks;
    int n_pass;
    int n_fail;

    // Expected pattern on a digit that leading-zero blanking would turn off.
`ifdef FND_BLANK_LZ_EN
    localparam logic [7:0] BLANK_Z = 8'hFF;
`else
    localparam logic [7:0] BLANK_Z = 8'hC0;
`endif

    fnd_scan_sched #(
        .DIV         (4),
        .HOLD_FRAMES (2)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_val       (val),
        .i_irq_req   (irq_req),
        .i_irq_val   (irq_val),
        .o_irq_ack   (irq_ack),
        .o_busy      (busy),
        .o_digit_sel (digit_sel),
        .o_seg       (seg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] sel, input logic [7:0] sg);
        chk({tag, ".sel"}, {12'h000, digit_sel}, {12'h000, sel});
        chk({tag, ".seg"}, {8'h00, seg}, {8'h00, sg});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        val      = 16'h1234;
        irq_req  = 1'b0;
        irq_val  = 16'h0000;

        // Reset
        step(3);
        chk_disp("rst", 4'b1110, 8'hC0);
        chk("rst.ack", {15'd0, irq_ack}, 16'd0);
        chk("rst.busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        chk_disp("e0", 4'b1110, 8'hC0);
        step(4);  chk_disp("e4", 4'b1101, 8'hC0);
        step(4);  chk_disp("e8", 4'b1011, 8'hC0);
        step(4);  chk_disp("e12", 4'b0111, 8'hC0);

        // Background value 1234, loaded at the first boundary
        step(4);  chk_disp("e16", 4'b1110, 8'h99);
        step(2);  val = 16'h5678;                       // mid-frame change
        step(2);  chk_disp("e20", 4'b1101, 8'hB0);
        step(4);  chk_disp("e24", 4'b1011, 8'hA4);
        step(4);  chk_disp("e28", 4'b0111, 8'hF9);
        step(4);  chk_disp("e32", 4'b1110, 8'h80);      // 5678 now shown
        val = 16'h1234;

        // Overlay ABCD requested mid-frame. The request is held through the
        // ack cycle, and that second sample must be ignored.
        step(1);  irq_req = 1'b1; irq_val = 16'hABCD;
        step(1);  chk("e34.ack", {15'd0, irq_ack}, 16'd1);
                  chk("e34.busy", {15'd0, busy}, 16'd1);
        step(1);  chk("e35.ack", {15'd0, irq_ack}, 16'd0);
                  chk("e35.busy", {15'd0, busy}, 16'd1);
                  chk_disp("e35", 4'b1110, 8'h80);
                  irq_req = 1'b0;
        step(1);  chk_disp("e36", 4'b1101, 8'hF8);
        step(12); chk_disp("e48", 4'b1110, 8'hA1);
                  chk("e48.busy", {15'd0, busy}, 16'd1);
        step(4);  chk_disp("e52", 4'b1101, 8'hC6);
        step(4);  chk_disp("e56", 4'b1011, 8'h83);
        step(4);  chk_disp("e60", 4'b0111, 8'h88);
        step(4);  chk_disp("e64", 4'b1110, 8'hA1);
        step(12); chk_disp("e76", 4'b0111, 8'h88);
                  chk("e76.busy", {15'd0, busy}, 16'd1);
        step(4);  chk_disp("e80", 4'b1110, 8'h99);
                  chk("e80.busy", {15'd0, busy}, 16'd0);
                  chk("e80.ack", {15'd0, irq_ack}, 16'd0);

        // Request sampled exactly on the boundary edge 96
        step(15); irq_req = 1'b1; irq_val = 16'hC0DE;
        step(1);  chk_disp("e96", 4'b1110, 8'h86);
                  chk("e96.ack", {15'd0, irq_ack}, 16'd1);
                  chk("e96.busy", {15'd0, busy}, 16'd1);
                  irq_req = 1'b0;
        step(4);  chk_disp("e100", 4'b1101, 8'hA1);
        step(12); chk_disp("e112", 4'b1110, 8'h86);
                  chk("e112.busy", {15'd0, busy}, 16'd1);
        step(16); chk_disp("e128", 4'b1110, 8'h99);
                  chk("e128.busy", {15'd0, busy}, 16'd0);

        // Retrigger with 00FF during overlay frame 1 of ABCD
        step(2);  irq_req = 1'b1; irq_val = 16'hABCD;
        step(1);  chk("e131.ack", {15'd0, irq_ack}, 16'd1);
                  irq_req = 1'b0;
        step(13); chk_disp("e144", 4'b1110, 8'hA1);
        step(2);  irq_req = 1'b1; irq_val = 16'h00FF;
        step(1);  chk("e147.ack", {15'd0, irq_ack}, 16'd1);
                  chk("e147.busy", {15'd0, busy}, 16'd1);
                  irq_req = 1'b0;
        step(1);  chk_disp("e148", 4'b1101, 8'hC6);     // still ABCD this frame
        step(12); chk_disp("e160", 4'b1110, 8'h8E);
        step(16); chk_disp("e176", 4'b1110, 8'h8E);     // hold restarted at 2
                  chk("e176.busy", {15'd0, busy}, 16'd1);
        step(8);  chk_disp("e184", 4'b1011, BLANK_Z);
        step(8);  chk_disp("e192", 4'b1110, 8'h99);
                  chk("e192.busy", {15'd0, busy}, 16'd0);

        // Reset during overlay frame 1
        step(1);  irq_req = 1'b1; irq_val = 16'hABCD;
        step(1);  chk("e194.ack", {15'd0, irq_ack}, 16'd1);
                  irq_req = 1'b0;
        step(14); chk_disp("e208", 4'b1110, 8'hA1);
        step(6);  chk_disp("e214", 4'b1101, 8'hC6);
                  rst_n = 1'b0;
        #1;       chk_disp("mrst", 4'b1110, 8'hC0);
                  chk("mrst.busy", {15'd0, busy}, 16'd0);
                  chk("mrst.ack", {15'd0, irq_ack}, 16'd0);
        step(2);  chk_disp("mrst2", 4'b1110, 8'hC0);
                  rst_n = 1'b1;
        step(16); chk_disp("r16", 4'b1110, 8'h99);
                  chk("r16.busy", {15'd0, busy}, 16'd0);
        step(16); chk_disp("r32", 4'b1110, 8'h99);
                  chk("r32.busy", {15'd0, busy}, 16'd0);
                  val = 16'h0042;

        // Leading-zero blanking patterns
        step(16); chk_disp("r48", 4'b1110, 8'hA4);
        step(4);  chk_disp("r52", 4'b1101, 8'h99);
        step(4);  chk_disp("r56", 4'b1011, BLANK_Z);
        step(4);  chk_disp("r60", 4'b0111, BLANK_Z);
                  val = 16'h0000;
        step(4);  chk_disp("r64", 4'b1110, 8'hC0);
        step(4);  chk_disp("r68", 4'b1101, BLANK_Z);
        step(4);  chk_disp("r72", 4'b1011, BLANK_Z);
        step(4);  chk_disp("r76", 4'b0111, BLANK_Z);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
